pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline sequencing controller for the 5-stage CPU core. It merges per-stage stall requests into the 6-bit `stall` vector consumed by the PC register and every inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB). It sequences exception and ERET redirects: freeze, one-cycle flush, then drain of any in-flight instruction fetch. It also keeps a saturating stall-cycle performance counter.

## Interface

Parameters:
- `EXC_VECTOR`, default 32'hBFC0_0380: redirect PC for every exception other than ERET.
- `ERET_CODE`, default 32'h0000_000E: `mem_excepttype` value meaning ERET.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `stallreq_if`  in  1  IF waiting on the instruction bus.
- `stallreq_id`  in  1  load-use hazard bubble request.
- `stallreq_ex`  in  1  multi-cycle mul/div busy.
- `stallreq_mem`  in  1  data bus transaction outstanding.
- `mem_excepttype`  in  32  exception code of the instruction in MEM; 0 means none.
- `cp0_epc`  in  32  EPC value, sampled at exception detection.
- `ibus_busy`  in  1  instruction-bus fetch in flight.
- `stall`  out  6  bit 0 PC, bit 1 IF/ID, bit 2 ID/EX, bit 3 EX/MEM, bit 4 MEM/WB, bit 5 WB; 1 = Stop.
- `flush`  out  1  clear all inter-stage registers.
- `new_pc`  out  32  redirect target; valid only while `flush` = 1.
- `discard_fetch`  out  1  drop the next returning fetch data.
- `stall_cnt`  out  32  cycles with `stall[0]` = 1, saturating.

## Operation

- FSM states: RUN, HOLD, FREEZE, FLUSH, DRAIN. The reset state is RUN.
- **Stall vector in RUN**, computed combinationally with highest-stage priority:
  - `stallreq_mem` gives 6'b011111.
  - Otherwise `stallreq_ex` gives 6'b001111.
  - Otherwise `stallreq_id` gives 6'b000111.
  - Otherwise `stallreq_if` gives 6'b000011.
  - Otherwise 6'b000000.
- **RUN with `mem_excepttype` != 0:**
  - Latch the target: `cp0_epc` if `mem_excepttype` == `ERET_CODE`, else `EXC_VECTOR`.
  - If `stallreq_mem` = 1, go to HOLD. Otherwise go to FREEZE.
  - The stall output in this detection cycle follows the RUN priority rules.
- **HOLD:**
  - `stall` = 6'b111111.
  - Stay while `stallreq_mem` = 1, then go to FREEZE.
  - New `mem_excepttype` values are ignored; the latched target is kept.
- **FREEZE:** `stall` = 6'b111111 for exactly one cycle, then go to FLUSH.
- **FLUSH:**
  - `flush` = 1, `new_pc` = latched target, `stall` = 0.
  - If `ibus_busy` = 1, go to DRAIN. Otherwise go to RUN.
- **DRAIN:**
  - `stall` = 6'b000011 and `discard_fetch` = 1.
  - Go to RUN on the first cycle with `ibus_busy` = 0. `discard_fetch` is still 1 in that cycle.
  - Exceptions and stall requests are ignored, because the pipeline is empty.
- **Performance counter:** `stall_cnt` increments by 1 every cycle `stall[0]` = 1, including HOLD, FREEZE and DRAIN. It holds at 32'hFFFF_FFFF.
- **Outside FLUSH:** `new_pc` = 0 and `flush` = 0.

## Timing

- **Reset values:**
  - `stall` = 0, `flush` = 0, `new_pc` = 0, `discard_fetch` = 0, `stall_cnt` = 0.
  - State returns to RUN.
  - A reset asserted mid-sequence (HOLD, FREEZE, FLUSH or DRAIN) aborts it at the next edge. No flush is issued afterwards.
- **Combinational paths:** `stall` in RUN is combinational from the `stallreq_*` inputs.
- **Registered outputs:** `flush`, `new_pc` and `discard_fetch` are registered state outputs; they carry no combinational path from any input.
- **Redirect latency:** with no memory stall, an exception seen at edge N gives FREEZE in cycle N+1 and `flush`/`new_pc` in cycle N+2. Each HOLD cycle adds one cycle.
- **`flush` width:** always exactly one cycle per exception.
- **Back-to-back:** an exception present in the first RUN cycle after DRAIN or FLUSH starts a new sequence.

## Test plan

- **Stall priority:** `stallreq_if`=1 and `stallreq_ex`=1 -> `stall`=6'b001111. Add `stallreq_mem`=1 -> 6'b011111. Drop all requests -> 6'b000000.
- **Plain exception:** `mem_excepttype`=32'h0000_0004 for 1 cycle, `ibus_busy`=0 -> one cycle of 6'b111111, then `flush`=1 with `new_pc`=32'hBFC0_0380 for exactly 1 cycle, then RUN.
- **ERET with memory stall:** `mem_excepttype`=32'h0000_000E, `cp0_epc`=32'h8000_1234, `stallreq_mem`=1 for 3 cycles -> HOLD for 3 cycles at 6'b111111, FREEZE for 1 cycle, then `flush` with `new_pc`=32'h8000_1234.
- **Fetch drain:** `ibus_busy`=1 during FLUSH and for 2 more cycles -> 3 cycles of `stall`=6'b000011 with `discard_fetch`=1, then RUN with `discard_fetch`=0.
- **Reset mid-sequence:** `rst`=1 during FREEZE -> next cycle all outputs 0, and no `flush` is ever asserted for that exception.
- **Counter:** `stallreq_if` held high for 10 cycles -> `stall_cnt`=10. Force `stall_cnt` to 32'hFFFF_FFFE and stall 3 cycles -> `stall_cnt`=32'hFFFF_FFFF.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges per-stage stall requests, sequences
// exception/ERET redirects (freeze, flush, fetch drain) and counts stall cycles.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [31:0] ERET_CODE  = 32'h0000_000E
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] mem_excepttype,
  input  logic [31:0] cp0_epc,
  input  logic        ibus_busy,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        discard_fetch,
  output logic [31:0] stall_cnt
);

  localparam int unsigned STW = 3;
  localparam int unsigned AW  = 32;

  localparam logic [STW-1:0] RUN    = 3'd0;
  localparam logic [STW-1:0] HOLD   = 3'd1;
  localparam logic [STW-1:0] FREEZE = 3'd2;
  localparam logic [STW-1:0] FLUSH  = 3'd3;
  localparam logic [STW-1:0] DRAIN  = 3'd4;

  logic [STW-1:0] state_q;
  logic [STW-1:0] state_d;
  logic [AW-1:0]  target_q;
  logic           exc_c;

  assign exc_c = (mem_excepttype != '0);

  // Next-state and stall vector; stall is combinational from requests in RUN
  always_comb begin
    state_d = state_q;
    stall   = 6'b000000;
    case (state_q)
      RUN: begin
        if (stallreq_mem)     stall = 6'b011111;
        else if (stallreq_ex) stall = 6'b001111;
        else if (stallreq_id) stall = 6'b000111;
        else if (stallreq_if) stall = 6'b000011;
        if (exc_c) state_d = stallreq_mem ? HOLD : FREEZE;
      end
      HOLD: begin
        stall = 6'b111111;
        if (!stallreq_mem) state_d = FREEZE;
      end
      FREEZE: begin
        stall   = 6'b111111;
        state_d = FLUSH;
      end
      FLUSH: begin
        stall   = 6'b000000;
        state_d = ibus_busy ? DRAIN : RUN;
      end
      DRAIN: begin
        stall = 6'b000011;
        if (!ibus_busy) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Redirect target is captured only at detection; later exceptions are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      target_q <= '0;
    end else if (state_q == RUN && exc_c) begin
      target_q <= (mem_excepttype == ERET_CODE) ? cp0_epc : EXC_VECTOR;
    end
  end

  // Flush/new_pc/discard are decoded from the next state so they are pure flops
  always_ff @(posedge clk) begin
    if (rst) begin
      flush         <= 1'b0;
      new_pc        <= '0;
      discard_fetch <= 1'b0;
    end else begin
      flush         <= (state_d == FLUSH);
      new_pc        <= (state_d == FLUSH) ? target_q : '0;
      discard_fetch <= (state_d == DRAIN);
    end
  end

  // Saturating count of cycles with the PC held
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall[0] && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [31:0] mem_excepttype;
  logic [31:0] cp0_epc;
  logic        ibus_busy;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        discard_fetch;
  logic [31:0] stall_cnt;

  int errors;
  int checks;

  pipe_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq_if    (stallreq_if),
    .stallreq_id    (stallreq_id),
    .stallreq_ex    (stallreq_ex),
    .stallreq_mem   (stallreq_mem),
    .mem_excepttype (mem_excepttype),
    .cp0_epc        (cp0_epc),
    .ibus_busy      (ibus_busy),
    .stall          (stall),
    .flush          (flush),
    .new_pc         (new_pc),
    .discard_fetch  (discard_fetch),
    .stall_cnt      (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stallreq_if    = 1'b0;
    stallreq_id    = 1'b0;
    stallreq_ex    = 1'b0;
    stallreq_mem   = 1'b0;
    mem_excepttype = 32'h0;
    cp0_epc        = 32'h0;
    ibus_busy      = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({stall, flush, discard_fetch} !== 8'h00 || new_pc !== 32'h0 || stall_cnt !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got stall=%b flush=%b dis=%b pc=%h cnt=%h exp all zero",
               stall, flush, discard_fetch, new_pc, stall_cnt);
    end
  endtask

  task automatic test_counter();
    do_reset();
    stallreq_if = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    stallreq_if = 1'b0;
    tick();
    checks++;
    if (stall_cnt !== 32'd10) begin
      errors++;
      $display("FAIL counter_10 got=%0d exp=10", stall_cnt);
    end
  endtask

  task automatic test_priority();
    do_reset();
    stallreq_if = 1'b1; stallreq_ex = 1'b1; #1;
    checks++;
    if (stall !== 6'b001111) begin
      errors++; $display("FAIL prio_if_ex got=%b exp=001111", stall);
    end
    stallreq_mem = 1'b1; #1;
    checks++;
    if (stall !== 6'b011111) begin
      errors++; $display("FAIL prio_mem got=%b exp=011111", stall);
    end
    stallreq_mem = 1'b0; stallreq_ex = 1'b0; stallreq_id = 1'b1; #1;
    checks++;
    if (stall !== 6'b000111) begin
      errors++; $display("FAIL prio_id got=%b exp=000111", stall);
    end
    stallreq_id = 1'b0; #1;
    checks++;
    if (stall !== 6'b000011) begin
      errors++; $display("FAIL prio_if got=%b exp=000011", stall);
    end
    stallreq_if = 1'b0; #1;
    checks++;
    if (stall !== 6'b000000) begin
      errors++; $display("FAIL prio_none got=%b exp=000000", stall);
    end
  endtask

  task automatic test_plain_exception();
    do_reset();
    mem_excepttype = 32'h0000_0004;
    tick();
    mem_excepttype = 32'h0;
    checks++;
    if (stall !== 6'b111111 || flush !== 1'b0) begin
      errors++; $display("FAIL exc_freeze got stall=%b flush=%b exp 111111/0", stall, flush);
    end
    tick();
    checks++;
    if (flush !== 1'b1 || new_pc !== 32'hBFC0_0380 || stall !== 6'b000000) begin
      errors++; $display("FAIL exc_flush got flush=%b pc=%h stall=%b exp 1/bfc00380/000000",
                         flush, new_pc, stall);
    end
    tick();
    checks++;
    if (flush !== 1'b0 || new_pc !== 32'h0 || discard_fetch !== 1'b0) begin
      errors++; $display("FAIL exc_after got flush=%b pc=%h dis=%b exp 0/0/0",
                         flush, new_pc, discard_fetch);
    end
  endtask

  task automatic test_eret_hold();
    do_reset();
    mem_excepttype = 32'h0000_000E;
    cp0_epc        = 32'h8000_1234;
    stallreq_mem   = 1'b1;
    #1;
    checks++;
    if (stall !== 6'b011111) begin
      errors++; $display("FAIL eret_detect got=%b exp=011111", stall);
    end
    tick();
    // Later exceptions and EPC changes must not disturb the latched target
    mem_excepttype = 32'h0000_0004;
    cp0_epc        = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) stallreq_mem = 1'b0;
      checks++;
      if (stall !== 6'b111111 || flush !== 1'b0) begin
        errors++; $display("FAIL eret_hold%0d got stall=%b flush=%b exp 111111/0", i, stall, flush);
      end
      tick();
    end
    mem_excepttype = 32'h0;
    checks++;
    if (stall !== 6'b111111 || flush !== 1'b0) begin
      errors++; $display("FAIL eret_freeze got stall=%b flush=%b exp 111111/0", stall, flush);
    end
    tick();
    checks++;
    if (flush !== 1'b1 || new_pc !== 32'h8000_1234) begin
      errors++; $display("FAIL eret_flush got flush=%b pc=%h exp 1/80001234", flush, new_pc);
    end
    tick();
    checks++;
    if (flush !== 1'b0) begin
      errors++; $display("FAIL eret_one_flush got=%b exp=0", flush);
    end
  endtask

  task automatic test_drain();
    do_reset();
    mem_excepttype = 32'h0000_0004;
    tick();
    mem_excepttype = 32'h0;
    ibus_busy      = 1'b1;
    tick();
    checks++;
    if (flush !== 1'b1 || discard_fetch !== 1'b0) begin
      errors++; $display("FAIL drain_flush got flush=%b dis=%b exp 1/0", flush, discard_fetch);
    end
    tick();
    // Requests and exceptions during drain are ignored
    stallreq_mem   = 1'b1;
    mem_excepttype = 32'h0000_0008;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        ibus_busy = 1'b0; stallreq_mem = 1'b0; mem_excepttype = 32'h0;
      end
      #1;
      checks++;
      if (stall !== 6'b000011 || discard_fetch !== 1'b1 || flush !== 1'b0) begin
        errors++; $display("FAIL drain%0d got stall=%b dis=%b flush=%b exp 000011/1/0",
                           i, stall, discard_fetch, flush);
      end
      tick();
    end
    checks++;
    if (discard_fetch !== 1'b0 || stall !== 6'b000000 || flush !== 1'b0) begin
      errors++; $display("FAIL drain_exit got dis=%b stall=%b flush=%b exp 0/000000/0",
                         discard_fetch, stall, flush);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    stallreq_if = 1'b1;
    tick();
    stallreq_if    = 1'b0;
    mem_excepttype = 32'h0000_0004;
    tick();
    mem_excepttype = 32'h0;
    rst            = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({stall, flush, discard_fetch} !== 8'h00 || new_pc !== 32'h0 || stall_cnt !== 32'h0) begin
      errors++;
      $display("FAIL midrst_outputs got stall=%b flush=%b dis=%b pc=%h cnt=%h exp all zero",
               stall, flush, discard_fetch, new_pc, stall_cnt);
    end
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
        tick();
        if (flush !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0) begin
        errors++; $display("FAIL midrst_noflush got flush_cycles=%0d exp=0", seen);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    mem_excepttype = 32'h0000_0004;
    tick();
    mem_excepttype = 32'h0;
    tick();
    checks++;
    if (flush !== 1'b1 || new_pc !== 32'hBFC0_0380) begin
      errors++; $display("FAIL b2b_flush1 got flush=%b pc=%h exp 1/bfc00380", flush, new_pc);
    end
    tick();
    mem_excepttype = 32'h0000_000E;
    cp0_epc        = 32'h1000_0040;
    tick();
    mem_excepttype = 32'h0;
    cp0_epc        = 32'h0;
    checks++;
    if (stall !== 6'b111111 || flush !== 1'b0) begin
      errors++; $display("FAIL b2b_freeze2 got stall=%b flush=%b exp 111111/0", stall, flush);
    end
    tick();
    checks++;
    if (flush !== 1'b1 || new_pc !== 32'h1000_0040) begin
      errors++; $display("FAIL b2b_flush2 got flush=%b pc=%h exp 1/10000040", flush, new_pc);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    @(negedge clk);
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    stallreq_if = 1'b1;
    tick();
    checks++;
    if (stall_cnt !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL sat_reach got=%h exp=ffffffff", stall_cnt);
    end
    tick();
    tick();
    stallreq_if = 1'b0;
    checks++;
    if (stall_cnt !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL sat_hold got=%h exp=ffffffff", stall_cnt);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    clear_inputs();
    test_reset();
    test_counter();
    test_priority();
    test_plain_exception();
    test_eret_hold();
    test_drain();
    test_reset_mid();
    test_back_to_back();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
